// File: rtl/dyn_text_line_s02_if.sv
`default_nettype none
// ============================================================================
//  Module   : dyn_text_line_s02_if
//  Brief    : Stream, character-buffer write and font-ROM signals of the
//             text-line overlay, grouped so the block drops into a chain.
//  Revision : 1.0  initial release
// ============================================================================
interface dyn_text_line_s02_if #(
    parameter int AW = 4
);
    logic [25:0]   RGBStr_i;
    logic [9:0]    posx_i;
    logic [9:0]    posy_i;
    logic          blink_en;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_char;
    logic [7:0]    rom_data;
    logic [25:0]   RGBStr_o;
    logic [9:0]    posx_o;
    logic [9:0]    posy_o;
    logic [10:0]   addr_rom;

    // Upstream / host side: drives the stream, the buffer writes and the ROM data
    modport master (
        output RGBStr_i, posx_i, posy_i, blink_en, wr_en, wr_addr, wr_char, rom_data,
        input  RGBStr_o, posx_o, posy_o, addr_rom
    );

    // Overlay block side
    modport slave (
        input  RGBStr_i, posx_i, posy_i, blink_en, wr_en, wr_addr, wr_char, rom_data,
        output RGBStr_o, posx_o, posy_o, addr_rom
    );
endinterface
`default_nettype wire

// File: rtl/dyn_text_line_s02.sv
`default_nettype none
// ============================================================================
//  Module   : dyn_text_line_s02
//  Brief    : Inline overlay drawing a line of NCHARS buffered characters,
//             magnified PSIZE times, from an external synchronous 8x8 font
//             ROM. Optional transparent background and VS-synced blink.
//             Four-stage pipeline, one pixel per clock, no stalls.
//  Revision : 1.0  initial release
// ============================================================================
module dyn_text_line_s02 #(
    parameter int         NCHARS      = 16,
    parameter int         PSIZE       = 2,
    parameter logic [2:0] COLOR_FG    = 3'b110,
    parameter logic [2:0] COLOR_BG    = 3'b001,
    parameter bit         ALPHA       = 1'b1,
    parameter int         BLINK_SHIFT = 4,
    parameter logic [7:0] SPACE_CHAR  = 8'h20
) (
    input logic               px_clk,
    input logic               reset,
    dyn_text_line_s02_if.slave bus
);

    // Geometry constants; NCHARS*8*PSIZE <= 1024 keeps every part-select
    // below inside the 10-bit offset.
    localparam int c_aw     = (NCHARS > 1) ? $clog2(NCHARS) : 1;
    localparam int c_psh    = $clog2(PSIZE);
    localparam int c_line_w = NCHARS * 8 * PSIZE;
    localparam int c_line_h = 8 * PSIZE;

    // Stream field positions
    localparam int c_act = 0;
    localparam int c_vs  = 1;

    // ------------------------------------------------------------------
    // Character buffer and frame counter state
    // ------------------------------------------------------------------
    logic [7:0]             r_buf [NCHARS];
    logic                   r_vs_prev;
    logic [BLINK_SHIFT:0]   r_cnt;

    // ------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------
    logic [25:0] r_s1_rgb, r_s2_rgb, r_s3_rgb, r_out_rgb;
    logic [9:0]  r_s1_posx, r_s2_posx, r_s3_posx, r_out_posx;
    logic [9:0]  r_s1_posy, r_s2_posy, r_s3_posy, r_out_posy;
    logic        r_s1_inside, r_s2_inside, r_s3_inside;
    logic [2:0]  r_s1_col, r_s2_col, r_s3_col;
    logic [2:0]  r_s1_row;
    logic [7:0]  r_s1_char;
    logic        r_s1_blink, r_s2_blink, r_s3_blink;
    logic [10:0] r_addr_rom;

    // ------------------------------------------------------------------
    // Stage 1 combinational geometry
    // ------------------------------------------------------------------
    logic [9:0]      w_dx;
    logic [9:0]      w_dy;
    logic            w_inside;
    logic [c_aw-1:0] w_idx;
    logic [2:0]      w_col;
    logic [2:0]      w_row;
    logic [7:0]      w_char;
    logic            w_wr_ok;

    // Offsets wrap modulo 1024, so pixels left of / above the corner land
    // far beyond the box and fall outside naturally.
    assign w_dx     = bus.RGBStr_i[22:13] - bus.posx_i;
    assign w_dy     = bus.RGBStr_i[12:3]  - bus.posy_i;
    assign w_inside = ({1'b0, w_dx} < 11'(c_line_w)) && ({1'b0, w_dy} < 11'(c_line_h));
    assign w_idx    = w_dx[3 + c_psh +: c_aw];
    assign w_col    = w_dx[c_psh +: 3];
    assign w_row    = w_dy[c_psh +: 3];
    assign w_wr_ok  = bus.wr_en && (int'(bus.wr_addr) < NCHARS);

    // Buffer read; the index is only meaningful when the pixel is inside
    always_comb begin
        w_char = 8'h00;
        if (w_inside) begin
            w_char = r_buf[w_idx];
        end
    end

    // Character buffer: space-filled on reset, written by the host port
    always_ff @(posedge px_clk) begin
        if (reset) begin
            for (int i = 0; i < NCHARS; i++) begin
                r_buf[i] <= SPACE_CHAR;
            end
        end else if (w_wr_ok) begin
            r_buf[bus.wr_addr[c_aw-1:0]] <= bus.wr_char;
        end
    end

    // Frame counter advanced on each rising VS of the incoming stream
    always_ff @(posedge px_clk) begin
        if (reset) begin
            r_vs_prev <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_vs_prev <= bus.RGBStr_i[c_vs];
            if (bus.RGBStr_i[c_vs] && !r_vs_prev) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Stage 1: capture the pixel and its glyph coordinates
    always_ff @(posedge px_clk) begin
        if (reset) begin
            r_s1_rgb    <= '0;
            r_s1_posx   <= '0;
            r_s1_posy   <= '0;
            r_s1_inside <= 1'b0;
            r_s1_col    <= '0;
            r_s1_row    <= '0;
            r_s1_char   <= '0;
            r_s1_blink  <= 1'b0;
        end else begin
            r_s1_rgb    <= bus.RGBStr_i;
            r_s1_posx   <= bus.posx_i;
            r_s1_posy   <= bus.posy_i;
            r_s1_inside <= w_inside;
            r_s1_col    <= w_col;
            r_s1_row    <= w_row;
            r_s1_char   <= w_char;
            r_s1_blink  <= bus.blink_en;
        end
    end

    // Stage 2: issue the font-ROM address; hold it for pixels outside the box
    always_ff @(posedge px_clk) begin
        if (reset) begin
            r_s2_rgb    <= '0;
            r_s2_posx   <= '0;
            r_s2_posy   <= '0;
            r_s2_inside <= 1'b0;
            r_s2_col    <= '0;
            r_s2_blink  <= 1'b0;
            r_addr_rom  <= '0;
        end else begin
            r_s2_rgb    <= r_s1_rgb;
            r_s2_posx   <= r_s1_posx;
            r_s2_posy   <= r_s1_posy;
            r_s2_inside <= r_s1_inside;
            r_s2_col    <= r_s1_col;
            r_s2_blink  <= r_s1_blink;
            if (r_s1_inside) begin
                r_addr_rom <= {r_s1_char, r_s1_row};
            end
        end
    end

    // Stage 3: wait out the ROM's one-cycle read latency
    always_ff @(posedge px_clk) begin
        if (reset) begin
            r_s3_rgb    <= '0;
            r_s3_posx   <= '0;
            r_s3_posy   <= '0;
            r_s3_inside <= 1'b0;
            r_s3_col    <= '0;
            r_s3_blink  <= 1'b0;
        end else begin
            r_s3_rgb    <= r_s2_rgb;
            r_s3_posx   <= r_s2_posx;
            r_s3_posy   <= r_s2_posy;
            r_s3_inside <= r_s2_inside;
            r_s3_col    <= r_s2_col;
            r_s3_blink  <= r_s2_blink;
        end
    end

    // ------------------------------------------------------------------
    // Stage 4 colour selection
    // ------------------------------------------------------------------
    logic       w_pix;
    logic       w_blank;
    logic [2:0] w_rgb;

    assign w_pix   = bus.rom_data[3'd7 - r_s3_col];
    assign w_blank = r_s3_blink && r_cnt[BLINK_SHIFT];

    // Paint glyph pixels; everything off-glyph or inactive keeps its colour
    always_comb begin
        w_rgb = r_s3_rgb[25:23];
        if (r_s3_rgb[c_act] && r_s3_inside) begin
            if (w_pix && !w_blank) begin
                w_rgb = COLOR_FG;
            end else if (!ALPHA) begin
                w_rgb = COLOR_BG;
            end
        end
    end

    // Stage 4: output register; sync and coordinate fields pass untouched
    always_ff @(posedge px_clk) begin
        if (reset) begin
            r_out_rgb  <= '0;
            r_out_posx <= '0;
            r_out_posy <= '0;
        end else begin
            r_out_rgb  <= {w_rgb, r_s3_rgb[22:0]};
            r_out_posx <= r_s3_posx;
            r_out_posy <= r_s3_posy;
        end
    end

    assign bus.RGBStr_o = r_out_rgb;
    assign bus.posx_o   = r_out_posx;
    assign bus.posy_o   = r_out_posy;
    assign bus.addr_rom = r_addr_rom;

endmodule
`default_nettype wire

// File: tb/tb_dyn_text_line_s02.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dyn_text_line_s02
//  Brief    : Randomised self-checking bench for dyn_text_line_s02. Two
//             instances (16 chars / x2 / transparent and 12 chars / x1 /
//             opaque) share stimulus and are compared with a pixel model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dyn_text_line_s02;

    logic clk;
    logic rst;

    dyn_text_line_s02_if #(.AW(4)) bus_a ();
    dyn_text_line_s02_if #(.AW(4)) bus_b ();

    dyn_text_line_s02 #(
        .NCHARS(16), .PSIZE(2), .ALPHA(1'b1)
    ) u_dut_a (
        .px_clk (clk),
        .reset  (rst),
        .bus    (bus_a)
    );

    dyn_text_line_s02 #(
        .NCHARS(12), .PSIZE(1), .ALPHA(1'b0)
    ) u_dut_b (
        .px_clk (clk),
        .reset  (rst),
        .bus    (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Font ROM image shared by both instances, each with its own read port
    logic [7:0] rom [2048];

    always @(posedge clk) begin
        bus_a.rom_data <= rom[bus_a.addr_rom];
        bus_b.rom_data <= rom[bus_b.addr_rom];
    end

    typedef struct {
        logic [25:0] rgb;
        logic [9:0]  px;
        logic [9:0]  py;
    } exp_t;

    typedef struct {
        bit          ins;
        logic [10:0] addr;
    } aexp_t;

    exp_t        qa[$], qb[$];
    aexp_t       aqa[$], aqb[$];
    logic [10:0] exp_addr_a, exp_addr_b;
    logic [7:0]  buf_a [16];
    logic [7:0]  buf_b [12];
    int          frames;
    bit          vs_prev_m;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Where a pixel falls on a line of nch characters magnified psz times
    function automatic void geom(input int nch, input int psz,
                                 input logic [9:0] xc, input logic [9:0] yc,
                                 input logic [9:0] px, input logic [9:0] py,
                                 output bit ins, output int idx, output int col, output int row);
        int dx;
        int dy;
        dx  = (int'(xc) - int'(px) + 1024) % 1024;
        dy  = (int'(yc) - int'(py) + 1024) % 1024;
        ins = (dx < nch * 8 * psz) && (dy < 8 * psz);
        idx = dx / (8 * psz);
        col = (dx / psz) % 8;
        row = (dy / psz) % 8;
    endfunction

    function automatic logic [2:0] colour(input logic [25:0] s, input bit ins,
                                          input logic [7:0] romw, input int col,
                                          input bit blank, input bit alpha);
        if (!s[0] || !ins) return s[25:23];
        if (romw[7 - col] && !blank) return 3'b110;
        return alpha ? s[25:23] : 3'b001;
    endfunction

    task automatic model_one(input bit is_a, input logic [25:0] s,
                             input logic [9:0] px, input logic [9:0] py, input bit blank);
        bit         ins;
        int         idx, col, row;
        logic [7:0] ch;
        logic [10:0] addr;
        exp_t       e;
        aexp_t      a;
        geom(is_a ? 16 : 12, is_a ? 2 : 1, s[22:13], s[12:3], px, py, ins, idx, col, row);
        ch   = 8'h00;
        if (ins) ch = is_a ? buf_a[idx] : buf_b[idx];
        addr = 11'(int'(ch) * 8 + row);
        e.rgb = {colour(s, ins, rom[addr], col, blank, is_a), s[22:0]};
        e.px  = px;
        e.py  = py;
        a.ins  = ins;
        a.addr = addr;
        if (is_a) begin qa.push_back(e); aqa.push_back(a); end
        else      begin qb.push_back(e); aqb.push_back(a); end
    endtask

    task automatic drive(input logic [25:0] s, input logic [9:0] px, input logic [9:0] py,
                         input logic blk, input logic we, input logic [3:0] wa, input logic [7:0] wc);
        bus_a.RGBStr_i = s;  bus_b.RGBStr_i = s;
        bus_a.posx_i   = px; bus_b.posx_i   = px;
        bus_a.posy_i   = py; bus_b.posy_i   = py;
        bus_a.blink_en = blk; bus_b.blink_en = blk;
        bus_a.wr_en    = we; bus_b.wr_en    = we;
        bus_a.wr_addr  = wa; bus_b.wr_addr  = wa;
        bus_a.wr_char  = wc; bus_b.wr_char  = wc;
    endtask

    // One pixel clock: drive, predict, then compare what has come out
    task automatic step(input logic [25:0] s, input logic [9:0] px, input logic [9:0] py,
                        input logic blk, input logic we, input logic [3:0] wa, input logic [7:0] wc);
        bit    blank;
        exp_t  e;
        aexp_t a;
        @(negedge clk);
        drive(s, px, py, blk, we, wa, wc);
        if (s[1] && !vs_prev_m) frames++;
        vs_prev_m = s[1];
        blank = blk && ((frames % 32) >= 16);
        model_one(1'b1, s, px, py, blank);
        model_one(1'b0, s, px, py, blank);
        if (we) begin
            buf_a[wa] = wc;
            if (wa < 12) buf_b[wa] = wc;
        end
        @(posedge clk);
        #1;
        if (qa.size() == 4) begin
            e = qa.pop_front();
            check("out_a", {bus_a.RGBStr_o, bus_a.posx_o, bus_a.posy_o}, {e.rgb, e.px, e.py});
        end
        if (qb.size() == 4) begin
            e = qb.pop_front();
            check("out_b", {bus_b.RGBStr_o, bus_b.posx_o, bus_b.posy_o}, {e.rgb, e.px, e.py});
        end
        if (aqa.size() == 2) begin
            a = aqa.pop_front();
            if (a.ins) exp_addr_a = a.addr;
            check("addr_a", bus_a.addr_rom, exp_addr_a);
        end
        if (aqb.size() == 2) begin
            a = aqb.pop_front();
            if (a.ins) exp_addr_b = a.addr;
            check("addr_b", bus_b.addr_rom, exp_addr_b);
        end
    endtask

    task automatic idle();
        step(26'd0, 10'd0, 10'd0, 1'b0, 1'b0, 4'd0, 8'd0);
    endtask

    function automatic logic [25:0] pixel(input logic [2:0] rgb, input logic [9:0] xc,
                                          input logic [9:0] yc, input logic act);
        return {rgb, xc, yc, 1'b0, 1'b0, act};
    endfunction

    // Synchronous reset; also flushes the model to match the cleared pipeline
    task automatic do_reset(input int cycles);
        exp_t  z;
        aexp_t za;
        @(negedge clk);
        rst = 1'b1;
        drive(26'd0, 10'd0, 10'd0, 1'b0, 1'b0, 4'd0, 8'd0);
        repeat (cycles) begin
            @(posedge clk);
            #1;
            check("rst_out_a", {bus_a.RGBStr_o, bus_a.posx_o, bus_a.posy_o}, 64'd0);
            check("rst_out_b", {bus_b.RGBStr_o, bus_b.posx_o, bus_b.posy_o}, 64'd0);
            check("rst_addr", {bus_a.addr_rom, bus_b.addr_rom}, 64'd0);
        end
        rst = 1'b0;
        for (int i = 0; i < 16; i++) buf_a[i] = 8'h20;
        for (int i = 0; i < 12; i++) buf_b[i] = 8'h20;
        frames = 0;
        vs_prev_m = 1'b0;
        qa.delete(); qb.delete(); aqa.delete(); aqb.delete();
        z.rgb = '0; z.px = '0; z.py = '0;
        za.ins = 1'b0; za.addr = '0;
        repeat (3) begin qa.push_back(z); qb.push_back(z); end
        aqa.push_back(za);
        aqb.push_back(za);
        exp_addr_a = '0;
        exp_addr_b = '0;
    endtask

    // Random pixels scattered around and inside the text box
    task automatic rand_run(input int n, input int blk_mode);
        logic [9:0]  px, py, xc, yc;
        logic [25:0] s;
        logic        blk;
        for (int i = 0; i < n; i++) begin
            px  = ($urandom_range(0, 3) == 0) ? 10'd100 : 10'($urandom_range(0, 1023));
            py  = ($urandom_range(0, 3) == 0) ? 10'd50  : 10'($urandom_range(0, 1023));
            xc  = 10'((int'(px) + int'($urandom_range(0, 272)) - 8 + 1024) % 1024);
            yc  = 10'((int'(py) + int'($urandom_range(0, 20)) - 2 + 1024) % 1024);
            s   = pixel(3'($urandom_range(0, 7)), xc, yc, $urandom_range(0, 7) != 0);
            s[2] = 1'($urandom_range(0, 1));
            blk = (blk_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(blk_mode);
            step(s, px, py, blk, $urandom_range(0, 3) == 0,
                 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
        end
    endtask

    task automatic vs_pulses(input int n);
        repeat (4) idle();
        repeat (n) begin
            step(26'b10, 10'd0, 10'd0, 1'b0, 1'b0, 4'd0, 8'd0);
            idle();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        drive(26'd0, 10'd0, 10'd0, 1'b0, 1'b0, 4'd0, 8'd0);
        for (int i = 0; i < 2048; i++) rom[i] = 8'($urandom_range(0, 255));
        rom[11'h208] = 8'h80;
        rom[11'h100] = 8'h00;
        rom[11'h101] = 8'h7F;

        do_reset(3);

        // Space glyph at the corner: background in both (opaque one paints BG)
        step(pixel(3'b010, 10'd100, 10'd50, 1'b1), 10'd100, 10'd50, 1'b0, 1'b1, 4'd0, 8'h41);
        // Same pixel after the write: 'A' row 0 leftmost bit set
        step(pixel(3'b010, 10'd100, 10'd50, 1'b1), 10'd100, 10'd50, 1'b0, 1'b0, 4'd0, 8'h00);
        // Second cell, glyph row 1 / column 0 on the magnified line
        step(pixel(3'b011, 10'd117, 10'd53, 1'b1), 10'd100, 10'd50, 1'b0, 1'b0, 4'd0, 8'h00);
        // Just left of and just below the box
        step(pixel(3'b101, 10'd99,  10'd50, 1'b1), 10'd100, 10'd50, 1'b0, 1'b0, 4'd0, 8'h00);
        step(pixel(3'b101, 10'd100, 10'd66, 1'b1), 10'd100, 10'd50, 1'b0, 1'b0, 4'd0, 8'h00);
        // Write beyond the 12-entry buffer, then read index 3 on the write edge
        step(pixel(3'b001, 10'd110, 10'd50, 1'b1), 10'd100, 10'd50, 1'b0, 1'b1, 4'd12, 8'h55);
        step(pixel(3'b100, 10'd148, 10'd52, 1'b1), 10'd100, 10'd50, 1'b0, 1'b1, 4'd3, 8'h42);
        step(pixel(3'b100, 10'd148, 10'd52, 1'b1), 10'd100, 10'd50, 1'b0, 1'b0, 4'd0, 8'h00);
        step(pixel(3'b100, 10'd103, 10'd51, 1'b1), 10'd100, 10'd50, 1'b0, 1'b0, 4'd0, 8'h00);
        repeat (4) idle();

        rand_run(600, 2);

        // Blink: 16 frames blanks the foreground, 16 more restores it
        vs_pulses(16);
        rand_run(200, 2);
        vs_pulses(16);
        rand_run(200, 1);
        vs_pulses(20);
        rand_run(150, 2);

        // Reset in the middle of a line
        rand_run(10, 0);
        do_reset(2);
        rand_run(300, 2);
        repeat (4) idle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
